inst_fetch: RTL and testbench

- Instruction fetch stage directly upstream of the instruction decoder.
- Holds the fetch PC and issues word reads to a synchronous instruction BRAM with 1-cycle read latency.
- Buffers returned words in a 2-entry queue so that downstream stalls never drop an instruction.
- Delivers {inst, pc} with a valid/ready handshake and accepts a redirect (branch/jump) that flushes everything in flight.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_queue.sv | 47 ++++
 rtl/inst_fetch.sv | 87 ++++++++
 tb/tb_inst_fetch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
// A fetch packet pairs an instruction word with its byte PC.
`timescale 1ns/1ps
package cpu_pkg;
    localparam int INST_W  = 32;
    localparam int PC_W    = 32;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_pkt_t;

    // Instruction PCs are always word aligned; low two bits are dropped.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return pc & ~PC_W'(3);
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of fetch packets, flushed on redirect.
// The head entry is presented combinationally to the decoder.
`timescale 1ns/1ps
module fetch_queue
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  fetch_pkt_t push_pkt,
    input  logic       pop,
    input  logic       flush,
    output logic [1:0] count,
    output fetch_pkt_t head
);

    fetch_pkt_t mem [2];
    logic       wr_ptr;
    logic       rd_ptr;

    // Entries are cleared on reset so the outputs never carry X.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_pkt;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC generation, credit-based BRAM reads and a
// two-entry output queue so decoder stalls never lose an instruction.
`timescale 1ns/1ps
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 15,
    parameter int          QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               rstn,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_inst,
    output logic [31:0]        out_pc
);

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] inflight_pc;
    logic            inflight;
    logic [1:0]      count;
    logic [2:0]      credit;
    logic            pop;
    logic            push;
    logic            issue;
    fetch_pkt_t      push_pkt;
    fetch_pkt_t      head;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & out_ready;
    assign push      = inflight & ~redirect;

    // A read may only be issued if its response is guaranteed a queue slot,
    // counting the outstanding read and any slot freed by this cycle's pop.
    // rstn gates issue so the BRAM is idle while reset is held.
    always_comb begin
        credit = 3'(count) + 3'(inflight);
        issue  = rstn & ~redirect & (credit < (3'(QDEPTH) + 3'(pop)));
    end

    assign imem_en   = issue;
    assign imem_addr = rstn ? fetch_pc[IMEM_AW+1:2] : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (redirect) begin
                fetch_pc <= align_pc(redirect_pc);
            end else if (issue) begin
                fetch_pc <= fetch_pc + PC_W'(PC_STEP);
            end
        end
    end

    // PC of the outstanding read; only consumed while inflight is set.
    always_ff @(posedge clk) begin
        if (issue) begin
            inflight_pc <= fetch_pc;
        end
    end

    assign push_pkt = '{inst: imem_rdata, pc: inflight_pc};

    fetch_queue u_queue (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push),
        .push_pkt (push_pkt),
        .pop      (pop),
        .flush    (redirect),
        .count    (count),
        .head     (head)
    );

    assign out_inst = head.inst;
    assign out_pc   = head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized and directed bench for inst_fetch against a transaction-level
// model of the fetch stream (expected PC sequence plus a 2-deep queue).
`timescale 1ns/1ps
module tb_inst_fetch;
    localparam int          IMEM_AW  = 15;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata = 32'h0;
    logic               redirect = 1'b0;
    logic [31:0]        redirect_pc = 32'h0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [31:0]        out_inst;
    logic [31:0]        out_pc;

    int total = 0;
    int bad   = 0;

    inst_fetch #(.RESET_PC(RESET_PC), .IMEM_AW(IMEM_AW), .QDEPTH(2)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc)
    );

    always #5 clk = ~clk;

    // BRAM contents: word[i] = i
    function automatic logic [31:0] word(input logic [IMEM_AW-1:0] a);
        return 32'(a);
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= word(imem_addr);
    end

    // Model: next PC to fetch, whether a read is outstanding and for which
    // PC, and the instructions waiting for the decoder.
    logic [31:0] m_fpc;
    logic        m_inf;
    logic [31:0] m_ipc;
    logic [31:0] mq_pc[$];

    // DUT values sampled in the last step, and the delivered stream.
    logic        s_valid, s_en;
    logic [31:0] s_inst, s_pc;
    logic [IMEM_AW-1:0] s_addr;
    logic [31:0] lg_inst[$];
    logic [31:0] lg_pc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fpc = RESET_PC;
        m_inf = 1'b0;
        m_ipc = 32'h0;
        mq_pc.delete();
    endtask

    task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
        logic m_valid, m_pop, m_issue;
        logic [31:0] wpc;
        @(negedge clk);
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        #4;
        m_valid = (mq_pc.size() != 0);
        m_pop   = m_valid && rdy;
        m_issue = !rd && ((mq_pc.size() + int'(m_inf) - int'(m_pop)) < 2);
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            wpc = mq_pc[0];
            chk("out_pc", out_pc, wpc);
            chk("out_inst", out_inst, word(wpc[IMEM_AW+1:2]));
        end
        chk("imem_en", 32'(imem_en), 32'(m_issue));
        if (m_issue) chk("imem_addr", 32'(imem_addr), 32'(m_fpc[IMEM_AW+1:2]));
        s_valid = out_valid; s_inst = out_inst; s_pc = out_pc;
        s_en = imem_en; s_addr = imem_addr;
        if (out_valid && rdy && !rd) begin
            lg_inst.push_back(out_inst);
            lg_pc.push_back(out_pc);
        end
        @(posedge clk);
        if (rd) begin
            mq_pc.delete();
            m_inf = 1'b0;
            m_fpc = rpc & ~32'h3;
        end else begin
            if (m_pop) void'(mq_pc.pop_front());
            if (m_inf) mq_pc.push_back(m_ipc);
            if (mq_pc.size() > 2) begin
                chk("queue_overflow", 32'(mq_pc.size()), 32'd2);
                void'(mq_pc.pop_back());
            end
            if (m_issue) begin
                m_ipc = m_fpc;
                m_fpc = m_fpc + 32'd4;
            end
            m_inf = m_issue;
        end
    endtask

    initial begin
        logic [31:0] held_inst, held_pc;
        model_reset();
        // reset state
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_imem_en", 32'(imem_en), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // free run from reset
        lg_inst.delete(); lg_pc.delete();
        step(1'b0, 32'h0, 1'b1);
        chk("lat_c0_valid", 32'(s_valid), 32'd0);
        chk("lat_c0_addr", 32'(s_addr), 32'd0);
        step(1'b0, 32'h0, 1'b1);
        chk("lat_c1_valid", 32'(s_valid), 32'd0);
        chk("lat_c1_addr", 32'(s_addr), 32'd1);
        step(1'b0, 32'h0, 1'b1);
        chk("lat_c2_valid", 32'(s_valid), 32'd1);
        repeat (3) step(1'b0, 32'h0, 1'b1);
        chk("run_count", 32'(lg_pc.size()), 32'd4);
        if (lg_pc.size() >= 3) begin
            chk("run0_inst", lg_inst[0], 32'd0); chk("run0_pc", lg_pc[0], 32'd0);
            chk("run1_inst", lg_inst[1], 32'd1); chk("run1_pc", lg_pc[1], 32'd4);
            chk("run2_inst", lg_inst[2], 32'd2); chk("run2_pc", lg_pc[2], 32'd8);
        end

        // stall for 5 cycles
        step(1'b0, 32'h0, 1'b0);
        held_inst = s_inst; held_pc = s_pc;
        repeat (4) step(1'b0, 32'h0, 1'b0);
        chk("stall_hold_inst", s_inst, held_inst);
        chk("stall_en_low", 32'(s_en), 32'd0);
        lg_inst.delete(); lg_pc.delete();
        repeat (6) step(1'b0, 32'h0, 1'b1);
        if (lg_pc.size() >= 2) begin
            chk("stall_resume_pc", lg_pc[0], held_pc);
            chk("stall_next_pc", lg_pc[1], held_pc + 32'd4);
        end else chk("stall_resume_cnt", 32'(lg_pc.size()), 32'd6);

        // redirect while the queue is full
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        chk("full_valid", 32'(s_valid), 32'd1);
        step(1'b1, 32'h100, 1'b0);
        lg_inst.delete(); lg_pc.delete();
        step(1'b0, 32'h0, 1'b1);
        chk("redir_en", 32'(s_en), 32'd1);
        chk("redir_addr", 32'(s_addr), 32'h40);
        chk("redir_valid0", 32'(s_valid), 32'd0);
        repeat (3) step(1'b0, 32'h0, 1'b1);
        if (lg_pc.size() >= 1) begin
            chk("redir_first_inst", lg_inst[0], 32'h40);
            chk("redir_first_pc", lg_pc[0], 32'h100);
        end else chk("redir_deliver_cnt", 32'(lg_pc.size()), 32'd1);

        // redirect coinciding with a pop and an incoming response
        repeat (3) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h203, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("rp_gap0", 32'(s_valid), 32'd0);
        step(1'b0, 32'h0, 1'b1);
        chk("rp_gap1", 32'(s_valid), 32'd0);
        step(1'b0, 32'h0, 1'b1);
        chk("rp_valid", 32'(s_valid), 32'd1);
        chk("rp_pc", s_pc, 32'h200);

        // PC wrap
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        lg_inst.delete(); lg_pc.delete();
        repeat (5) step(1'b0, 32'h0, 1'b1);
        if (lg_pc.size() >= 2) begin
            chk("wrap_pc0", lg_pc[0], 32'hFFFF_FFFC);
            chk("wrap_inst0", lg_inst[0], 32'h7FFF);
            chk("wrap_pc1", lg_pc[1], 32'h0);
            chk("wrap_inst1", lg_inst[1], 32'h0);
        end else chk("wrap_cnt", 32'(lg_pc.size()), 32'd2);

        // async reset with the queue full
        repeat (3) step(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_en", 32'(imem_en), 32'd0);
        model_reset();
        redirect = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        step(1'b0, 32'h0, 1'b1);
        chk("arst_restart_en", 32'(s_en), 32'd1);
        chk("arst_restart_addr", 32'(s_addr), 32'(RESET_PC[IMEM_AW+1:2]));

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
